// File: rtl/pmod_gpi_pkg.sv
// Shared register map, reset values and per-bit conditioner state for the PMOD GPI
// input conditioner.
package pmod_gpi_pkg;

  localparam int unsigned CNT_MAX_W = 32;

  localparam logic [31:0] DEB_LIMIT_OFFS = 32'h00;
  localparam logic [31:0] LEVEL_OFFS     = 32'h04;
  localparam logic [31:0] RISE_EN_OFFS   = 32'h08;
  localparam logic [31:0] FALL_EN_OFFS   = 32'h0C;
  localparam logic [31:0] EVENT_OFFS     = 32'h10;

  localparam logic [31:0] DEB_LIMIT_RST = '0;
  localparam logic [31:0] RISE_EN_RST   = '0;
  localparam logic [31:0] FALL_EN_RST   = '0;
  localparam logic [31:0] EVENT_RST     = '0;

  // cnt is sized for the widest legal DEB_W; unused upper bits stay 0.
  typedef struct packed {
    logic                 s1;
    logic                 s2;
    logic                 deb;
    logic [CNT_MAX_W-1:0] cnt;
  } gpi_bit_state_t;

  localparam gpi_bit_state_t GPI_BIT_RST = '0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_DEB_LIMIT,
    SEL_LEVEL,
    SEL_RISE_EN,
    SEL_FALL_EN,
    SEL_EVENT
  } reg_sel_t;

  function automatic reg_sel_t decode_addr(input logic [31:0] addr);
    case (addr)
      DEB_LIMIT_OFFS: decode_addr = SEL_DEB_LIMIT;
      LEVEL_OFFS:     decode_addr = SEL_LEVEL;
      RISE_EN_OFFS:   decode_addr = SEL_RISE_EN;
      FALL_EN_OFFS:   decode_addr = SEL_FALL_EN;
      EVENT_OFFS:     decode_addr = SEL_EVENT;
      default:        decode_addr = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gpi_debounce_bit.sv
// One conditioned input: 2-flop synchroniser, stable-count debouncer and
// single-cycle rise/fall pulses aligned with the debounced level update.
module gpi_debounce_bit #(
  parameter int unsigned DEB_W = 16
) (
  input  logic             clk_in,
  input  logic             reset_int,
  input  logic             i_pad,
  input  logic [DEB_W-1:0] i_limit,
  output logic             o_level,
  output logic             o_rise,
  output logic             o_fall
);
  import pmod_gpi_pkg::*;

  gpi_bit_state_t       r_st;
  logic                 w_mismatch;
  logic                 w_update;
  logic [CNT_MAX_W-1:0] w_limit;

  // >= rather than == so a lowered limit mid-count releases on the next edge.
  always_comb begin
    w_limit    = CNT_MAX_W'(i_limit);
    w_mismatch = r_st.s2 != r_st.deb;
    w_update   = w_mismatch && (r_st.cnt >= w_limit);
  end

  always_ff @(posedge clk_in) begin
    if (reset_int) begin
      r_st <= GPI_BIT_RST;
    end else begin
      r_st.s1 <= i_pad;
      r_st.s2 <= r_st.s1;
      if (w_update) begin
        r_st.deb <= r_st.s2;
        r_st.cnt <= '0;
      end else if (w_mismatch) begin
        r_st.cnt <= r_st.cnt + CNT_MAX_W'(1);
      end else begin
        r_st.cnt <= '0;
      end
    end
  end

  assign o_level = r_st.deb;
  assign o_rise  = w_update & r_st.s2;
  assign o_fall  = w_update & ~r_st.s2;

endmodule

// File: rtl/pmod_gpi_conditioner.sv
// PMOD input conditioner: per-bit debounce, sticky edge events with interrupt,
// and a zero-wait-state APB register slave.
module pmod_gpi_conditioner #(
  parameter int unsigned APB_AW = 10,
  parameter int unsigned APB_DW = 32,
  parameter int unsigned N_GPI  = 16,
  parameter int unsigned DEB_W  = 16
) (
  input  logic                clk_in,
  input  logic                reset_int,
  input  logic [APB_AW-1:0]   PADDR,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [APB_DW-1:0]   PWDATA,
  input  logic [APB_DW/8-1:0] PSTRB,
  output logic [APB_DW-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  input  logic                irq_en,
  input  logic [N_GPI-1:0]    pad_gpi,
  output logic [N_GPI-1:0]    gpi_clean,
  output logic                irq
);
  import pmod_gpi_pkg::*;

  logic [DEB_W-1:0]  r_deb_limit;
  logic [N_GPI-1:0]  r_rise_en;
  logic [N_GPI-1:0]  r_fall_en;
  logic [N_GPI-1:0]  r_event;

  logic [N_GPI-1:0]  w_level;
  logic [N_GPI-1:0]  w_rise;
  logic [N_GPI-1:0]  w_fall;
  logic [N_GPI-1:0]  w_set;
  logic [N_GPI-1:0]  w_clr;
  reg_sel_t          w_sel;
  logic              w_access;
  logic              w_err;
  logic              w_wr;
  logic [APB_DW-1:0] w_rmux;
  logic              w_unused_pwdata;

  for (genvar g = 0; g < N_GPI; g++) begin : g_bit
    gpi_debounce_bit #(.DEB_W(DEB_W)) u_bit (
      .clk_in    (clk_in),
      .reset_int (reset_int),
      .i_pad     (pad_gpi[g]),
      .i_limit   (r_deb_limit),
      .o_level   (w_level[g]),
      .o_rise    (w_rise[g]),
      .o_fall    (w_fall[g])
    );
  end

  // Access is masked by reset so a transfer caught by reset is abandoned.
  always_comb begin
    w_sel    = decode_addr(32'(PADDR));
    w_access = PSEL & PENABLE & ~reset_int;
    w_err    = (w_sel == SEL_NONE);
    if (PWRITE && ((w_sel == SEL_LEVEL) || (PSTRB != '1))) w_err = 1'b1;
    w_wr     = w_access & PWRITE & ~w_err;

    w_rmux = '0;
    case (w_sel)
      SEL_DEB_LIMIT: w_rmux = APB_DW'(r_deb_limit);
      SEL_LEVEL:     w_rmux = APB_DW'(w_level);
      SEL_RISE_EN:   w_rmux = APB_DW'(r_rise_en);
      SEL_FALL_EN:   w_rmux = APB_DW'(r_fall_en);
      SEL_EVENT:     w_rmux = APB_DW'(r_event);
      default:       w_rmux = '0;
    endcase

    PREADY  = w_access;
    PSLVERR = w_access & w_err;
    PRDATA  = w_access ? w_rmux : '0;

    w_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    w_clr = (w_wr && (w_sel == SEL_EVENT)) ? PWDATA[N_GPI-1:0] : '0;
  end

  always_ff @(posedge clk_in) begin
    if (reset_int) begin
      r_deb_limit <= DEB_LIMIT_RST[DEB_W-1:0];
      r_rise_en   <= RISE_EN_RST[N_GPI-1:0];
      r_fall_en   <= FALL_EN_RST[N_GPI-1:0];
      r_event     <= EVENT_RST[N_GPI-1:0];
    end else begin
      if (w_wr && (w_sel == SEL_DEB_LIMIT)) r_deb_limit <= PWDATA[DEB_W-1:0];
      if (w_wr && (w_sel == SEL_RISE_EN))   r_rise_en   <= PWDATA[N_GPI-1:0];
      if (w_wr && (w_sel == SEL_FALL_EN))   r_fall_en   <= PWDATA[N_GPI-1:0];
      // Set applied after clear: a coincident new event survives the W1C.
      r_event <= (r_event & ~w_clr) | w_set;
    end
  end

  assign gpi_clean       = w_level;
  assign irq             = irq_en & (|r_event);
  assign w_unused_pwdata = &{1'b0, PWDATA};

endmodule

// File: tb/tb_pmod_gpi_conditioner.sv
// Scoreboard bench for pmod_gpi_conditioner: APB expectations are queued by the
// stimulus and checked by a monitor whenever PREADY is presented.
module tb_pmod_gpi_conditioner;

  logic        clk_in = 1'b0;
  logic        reset_int = 1'b1;
  logic [9:0]  PADDR = '0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        irq_en = 1'b0;
  logic [15:0] pad_gpi = '0;
  logic [15:0] gpi_clean;
  logic        irq;

  pmod_gpi_conditioner #(.APB_AW(10), .APB_DW(32), .N_GPI(16), .DEB_W(16)) dut (
    .clk_in    (clk_in),
    .reset_int (reset_int),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .irq_en    (irq_en),
    .pad_gpi   (pad_gpi),
    .gpi_clean (gpi_clean),
    .irq       (irq)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (PREADY === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pready: got PREADY=1 at %0t, expected no transfer", $time);
      end else begin
        e = q.pop_front();
        chk({e.name, ".pslverr"}, 32'(PSLVERR), 32'(e.err));
        if (e.chk_data) chk({e.name, ".prdata"}, PRDATA, e.rdata);
      end
    end
  end

  task automatic apb(input string name, input logic [31:0] addr, input logic wr,
                     input logic [31:0] data, input logic [3:0] strb,
                     input logic [31:0] exp_rd, input logic exp_err);
    @(posedge clk_in); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr[9:0];
    PWRITE = wr; PWDATA = data; PSTRB = strb;
    q.push_back('{name, exp_rd, exp_err, !wr});
    @(posedge clk_in); #1;
    PENABLE = 1'b1;
    @(posedge clk_in); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp_rd);
    apb(name, addr, 1'b0, 32'h0, 4'h0, exp_rd, 1'b0);
  endtask

  task automatic rd_err(input string name, input logic [31:0] addr);
    apb(name, addr, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
  endtask

  task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data);
    apb(name, addr, 1'b1, data, 4'hF, 32'h0, 1'b0);
  endtask

  task automatic wr_err(input string name, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb);
    apb(name, addr, 1'b1, data, strb, 32'h0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst.gpi_clean", 32'(gpi_clean), 32'h0);
    chk("rst.irq", 32'(irq), 32'h0);
    chk("rst.pready", 32'(PREADY), 32'h0);
    chk("rst.pslverr", 32'(PSLVERR), 32'h0);
    chk("rst.prdata", PRDATA, 32'h0);
    reset_int = 1'b0;

    rd("rst.deb_limit", 32'h00, 32'h0);
    rd("rst.level", 32'h04, 32'h0);
    rd("rst.rise_en", 32'h08, 32'h0);
    rd("rst.fall_en", 32'h0C, 32'h0);
    rd("rst.event", 32'h10, 32'h0);
    rd_err("rst.unmapped14", 32'h14);

    // DEB_LIMIT=0 rising edge on bit 0
    wr("l0.deb_limit", 32'h00, 32'h0);
    wr("l0.rise_en", 32'h08, 32'h0001);
    rd("l0.rise_en_rb", 32'h08, 32'h0001);
    irq_en = 1'b1;
    pad_gpi[0] = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in); #1;
    chk("l0.clean_k1", 32'(gpi_clean[0]), 32'h0);
    chk("l0.irq_k1", 32'(irq), 32'h0);
    @(posedge clk_in); #1;
    chk("l0.clean_k2", 32'(gpi_clean[0]), 32'h1);
    chk("l0.irq_k2", 32'(irq), 32'h1);
    rd("l0.event", 32'h10, 32'h0001);
    rd("l0.level", 32'h04, 32'h0001);
    wr("l0.w1c", 32'h10, 32'h0001);
    chk("l0.irq_cleared", 32'(irq), 32'h0);
    rd("l0.event_cleared", 32'h10, 32'h0);

    // DEB_LIMIT=5 glitch rejection then acceptance on bit 3
    wr("l5.deb_limit", 32'h00, 32'h5);
    pad_gpi[3] = 1'b1;
    repeat (5) @(posedge clk_in);
    #1 pad_gpi[3] = 1'b0;
    repeat (12) @(posedge clk_in);
    #1;
    chk("l5.glitch5", 32'(gpi_clean[3]), 32'h0);
    pad_gpi[3] = 1'b1;
    repeat (6) @(posedge clk_in);
    #1 pad_gpi[3] = 1'b0;
    @(posedge clk_in); #1;
    chk("l5.pulse6_k6", 32'(gpi_clean[3]), 32'h0);
    @(posedge clk_in); #1;
    chk("l5.pulse6_k7", 32'(gpi_clean[3]), 32'h1);
    repeat (10) @(posedge clk_in);
    #1;
    chk("l5.fall_back", 32'(gpi_clean[3]), 32'h0);
    rd("l5.event", 32'h10, 32'h0);

    // Fall event coinciding with W1C on bit 15
    wr("f.deb_limit", 32'h00, 32'h0);
    wr("f.fall_en", 32'h0C, 32'h8000);
    pad_gpi[15] = 1'b1;
    repeat (4) @(posedge clk_in);
    #1;
    chk("f.clean15_high", 32'(gpi_clean[15]), 32'h1);
    rd("f.event_before", 32'h10, 32'h0);
    @(posedge clk_in);
    #1 pad_gpi[15] = 1'b0;
    wr("f.w1c_coincident", 32'h10, 32'h8000);
    chk("f.irq_set_wins", 32'(irq), 32'h1);
    rd("f.event_set_wins", 32'h10, 32'h8000);
    wr("f.fall_en_off", 32'h0C, 32'h0);
    rd("f.event_kept", 32'h10, 32'h8000);
    wr("f.w1c", 32'h10, 32'h8000);
    rd("f.event_clear", 32'h10, 32'h0);
    chk("f.irq_clear", 32'(irq), 32'h0);

    // Lowering DEB_LIMIT mid-count releases on the next edge
    wr("s.deb_limit100", 32'h00, 32'd100);
    pad_gpi[3] = 1'b1;
    repeat (38) @(posedge clk_in);
    wr("s.deb_limit10", 32'h00, 32'd10);
    chk("s.before", 32'(gpi_clean[3]), 32'h0);
    @(posedge clk_in); #1;
    chk("s.after", 32'(gpi_clean[3]), 32'h1);

    // Errored writes change nothing
    wr_err("e.wr_level", 32'h04, 32'hFFFF, 4'hF);
    rd("e.level", 32'h04, 32'h0009);
    wr_err("e.wr_strb0011", 32'h00, 32'h7, 4'b0011);
    rd("e.deb_limit", 32'h00, 32'd10);
    wr_err("e.wr_strb1110", 32'h08, 32'hFFFF, 4'b1110);
    rd("e.rise_en", 32'h08, 32'h0001);
    wr_err("e.wr_unmapped", 32'h14, 32'hFFFF, 4'hF);
    rd_err("e.rd_unaligned", 32'h02);

    // Reset mid-debounce and mid-transfer
    wr("r.rise_en", 32'h08, 32'hFFFF);
    pad_gpi[7] = 1'b1;
    repeat (15) @(posedge clk_in);
    #1;
    chk("r.irq_pre", 32'(irq), 32'h1);
    rd("r.event_pre", 32'h10, 32'h0080);
    pad_gpi[9] = 1'b1;
    repeat (5) @(posedge clk_in);
    @(posedge clk_in); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 10'h10; PWRITE = 1'b0;
    @(posedge clk_in); #1;
    PENABLE = 1'b1;
    reset_int = 1'b1;
    #1;
    chk("r.pready_held", 32'(PREADY), 32'h0);
    chk("r.pslverr_held", 32'(PSLVERR), 32'h0);
    chk("r.prdata_held", PRDATA, 32'h0);
    @(posedge clk_in); #1;
    chk("r.gpi_clean", 32'(gpi_clean), 32'h0);
    chk("r.irq", 32'(irq), 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 reset_int = 1'b0;
    rd("r.deb_limit", 32'h00, 32'h0);
    rd("r.rise_en", 32'h08, 32'h0);
    rd("r.fall_en", 32'h0C, 32'h0);
    rd("r.event", 32'h10, 32'h0);
    rd("r.level", 32'h04, 32'h0289);
    chk("r.irq_post", 32'(irq), 32'h0);

    repeat (2) @(posedge clk_in);
    chk("sb.drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
